cardinal_nic: RTL

CARDINAL_NIC -- requirements
Module: cardinal_nic

---
 rtl/cardinal_pkg.sv | 40 ++++
 rtl/cardinal_nic_buf.sv | 32 +++
 rtl/cardinal_nic.sv | 108 ++++++++++
 3 files changed

// File: rtl/cardinal_pkg.sv
// Shared definitions for the cardinal NIC.
// Holds the packet width, packet field bit positions, the processor
// register select codes and the status word layout.
package cardinal_pkg;

    localparam int PACKET_SIZE = 64;

    // Packet field positions; the NIC never rewrites any of these
    localparam int VC_BIT   = 63;
    localparam int DIR_BIT  = 62;
    localparam int HOP_HI   = 55;
    localparam int HOP_LO   = 48;
    localparam int SRC_HI   = 47;
    localparam int SRC_LO   = 32;
    localparam int DATA_HI  = 31;
    localparam int DATA_LO  = 0;

    // Processor register select codes
    localparam logic [1:0] ADDR_IBUF    = 2'b00;
    localparam logic [1:0] ADDR_IBUF_ST = 2'b01;
    localparam logic [1:0] ADDR_OBUF    = 2'b10;
    localparam logic [1:0] ADDR_OBUF_ST = 2'b11;

    // Status word: flag in bit 0, optional counters above it
    localparam int CNT_W = 16;

    function automatic logic [PACKET_SIZE-1:0] status_word(
        input logic             flag,
        input logic [CNT_W-1:0] inj,
        input logic [CNT_W-1:0] ej
    );
        logic [PACKET_SIZE-1:0] w;
        w        = '0;
        w[0]     = flag;
        w[47:32] = inj;
        w[31:16] = ej;
        return w;
    endfunction

endpackage

// File: rtl/cardinal_nic_buf.sv
// Single-entry packet register with a full flag.
// Ports: clk, reset (async active-high), load (capture d, set full),
// clear (drop full, keep contents), d, q (held packet), full.
// Load wins over clear; callers never assert both since load requires
// the buffer to be empty and clear requires it to be full.
module cardinal_nic_buf
    import cardinal_pkg::*;
#(
    parameter int W = PACKET_SIZE
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic         clear,
    input  logic [W-1:0] d,
    output logic [W-1:0] q,
    output logic         full
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q    <= '0;
            full <= 1'b0;
        end else if (load) begin
            q    <= d;
            full <= 1'b1;
        end else if (clear) begin
            full <= 1'b0;
        end
    end

endmodule

// File: rtl/cardinal_nic.sv
// Cardinal network interface: one-packet OBUF toward the router PE input
// port and one-packet IBUF from the router PE output port, both accessed
// by the processor through a 2-bit register select.
// Ports:
//   clk, reset            clock, async active-high reset
//   addr, d_in, d_out     processor register select / write data / read data
//   nicEn, nicWrEn        processor access enable / write strobe
//   net_so, net_ro, net_do  injection handshake (send, ready, data)
//   net_si, net_ri, net_di  ejection handshake (send, ready, data)
//   net_polarity          ring phase; a packet leaves only when its VC
//                         bit differs from the current phase
// Optional feature macro CARDINAL_NIC_STATS_EN adds 16-bit wrapping
// injection/ejection counters reported in the status reads.
module cardinal_nic
    import cardinal_pkg::*;
(
    input  logic                   clk,
    input  logic                   reset,
    input  logic [1:0]             addr,
    input  logic [PACKET_SIZE-1:0] d_in,
    output logic [PACKET_SIZE-1:0] d_out,
    input  logic                   nicEn,
    input  logic                   nicWrEn,
    output logic                   net_so,
    input  logic                   net_ro,
    output logic [PACKET_SIZE-1:0] net_do,
    input  logic                   net_si,
    output logic                   net_ri,
    input  logic [PACKET_SIZE-1:0] net_di,
    input  logic                   net_polarity
);

    logic [PACKET_SIZE-1:0] obuf_q, ibuf_q;
    logic                   obuf_full, ibuf_full;
    logic                   obuf_load, ibuf_load, ibuf_clear;
    logic                   rd_en, inject, eject;
    logic [CNT_W-1:0]       inj_val, ej_val;

    assign rd_en  = nicEn & ~nicWrEn;

    // reset gating keeps the handshakes quiet for the whole reset window
    assign net_so = obuf_full & net_ro & (net_polarity != obuf_q[VC_BIT]) & ~reset;
    assign net_ri = ~ibuf_full & ~reset;
    assign net_do = obuf_q;

    assign inject = net_so;
    assign eject  = net_si & net_ri;

    // write is judged against the registered flag, so a write in the
    // injection cycle is dropped and refill waits one cycle
    assign obuf_load  = nicEn & nicWrEn & (addr == ADDR_OBUF) & ~obuf_full;
    assign ibuf_load  = eject;
    assign ibuf_clear = rd_en & (addr == ADDR_IBUF) & ibuf_full;

    cardinal_nic_buf u_obuf (
        .clk   (clk),
        .reset (reset),
        .load  (obuf_load),
        .clear (inject),
        .d     (d_in),
        .q     (obuf_q),
        .full  (obuf_full)
    );

    cardinal_nic_buf u_ibuf (
        .clk   (clk),
        .reset (reset),
        .load  (ibuf_load),
        .clear (ibuf_clear),
        .d     (net_di),
        .q     (ibuf_q),
        .full  (ibuf_full)
    );

`ifdef CARDINAL_NIC_STATS_EN
    logic [CNT_W-1:0] inj_cnt, ej_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            inj_cnt <= '0;
            ej_cnt  <= '0;
        end else begin
            if (inject) inj_cnt <= inj_cnt + 1'b1;
            if (eject)  ej_cnt  <= ej_cnt + 1'b1;
        end
    end

    assign inj_val = inj_cnt;
    assign ej_val  = ej_cnt;
`else
    assign inj_val = '0;
    assign ej_val  = '0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            d_out <= '0;
        end else if (rd_en) begin
            case (addr)
                ADDR_IBUF:    d_out <= ibuf_q;
                ADDR_IBUF_ST: d_out <= status_word(ibuf_full, inj_val, ej_val);
                ADDR_OBUF_ST: d_out <= status_word(obuf_full, inj_val, ej_val);
                default:      d_out <= '0;
            endcase
        end
    end

endmodule
